fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Top-level sequencer for the in-place radix-2 DIF FFT core. It streams N input samples into the two conflict-free memory banks (m0/m1) and runs R butterfly stages, issuing one butterfly read per cycle and a delayed write-back. It then streams the result out in natural frequency order. It sits between the sample interface and the bank RAMs, butterfly unit and twiddle ROM, and replaces free-running address counting with a handshaked, pipeline-aware schedule.

## Interface
- R, 5, log2 of transform size
- N, 32, transform size (must equal 2^R)
- BF_LAT, 3, butterfly unit latency in cycles (read data to write data)
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  start request; honoured only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the transform completes
- i_in_valid  in  1  input sample valid
- o_in_ready  out  1  high throughout LOAD
- o_ld_we  out  1  load-phase write strobe
- o_ld_bank  out  1  bank selected for the load write
- o_ld_addr  out  R-1  address within the bank for the load write
- o_rd_en  out  1  butterfly/unload read strobe, both banks
- o_rd_a0, o_rd_a1  out  R-1 each  m0/m1 read addresses
- o_rd_swap  out  1  1 = upper operand p lives in m1 (datapath swaps)
- o_tw_idx  out  R-1  twiddle index for the issued butterfly
- o_wr_en  out  1  butterfly write-back strobe, both banks
- o_wr_a0, o_wr_a1  out  R-1 each  write-back addresses
- o_wr_swap  out  1  swap control aligned to write-back
- o_out_valid  out  1  output sample valid (no backpressure)
- o_out_idx  out  R  frequency index of the output sample
- o_out_bank  out  1  bank holding the current output sample

## Operation
- Bank mapping for sample index x: bank = XOR of all bits of x, address = x >> 1.
- States: IDLE, LOAD, COMP, DRAIN, UNLOAD, DONE.
- IDLE: i_start -> LOAD. i_start is ignored in any other state.
- LOAD: o_in_ready=1. On each i_in_valid, write sample k (k=0..N-1, natural order) combinationally: o_ld_we=1, bank/addr from the mapping. After k=N-1 is accepted -> COMP.
- COMP: stage s=0..R-1, butterfly b=0..N/2-1, one butterfly per cycle.
  - m = R-1-s.
  - p = ((b>>m)<<(m+1)) | (b & (2^m-1)), q = p | 2^m.
  - The bank holding p gets p>>1 and the other bank gets q>>1.
  - o_rd_swap = parity(p).
  - o_tw_idx = (b mod 2^m) << s.
- After the last b of a stage -> DRAIN.
- DRAIN: no reads for BF_LAT+1 cycles, so all writes of the stage retire before the next stage reads. Then -> COMP with s+1, or -> UNLOAD after s=R-1.
- Write-back: a shift register of depth BF_LAT+1 carries {valid, a0, a1, swap} from each read. o_wr_* equals the read issue delayed by exactly BF_LAT+1 cycles. There is one memory read cycle before the butterfly.
- UNLOAD: for k=0..N-1, one read per cycle of index x = bitrev(k); o_rd_a0 = o_rd_a1 = x>>1. One cycle later: o_out_valid=1, o_out_idx=k, o_out_bank=parity(x). After k=N-1 -> DONE.
- DONE: o_done=1 for one cycle (aligned with the final o_out_valid) -> IDLE.
- Counters wrap exactly at their bounds; no arithmetic exceeds the declared widths.

## Timing
- Reset: state IDLE, all counters 0, delay line cleared (pending writes discarded). Every output is 0, including o_in_ready, o_busy and o_done. This applies mid-transform as well.
- o_busy rises the cycle after i_start is sampled in IDLE.
- LOAD length = N accepted samples. Gaps in i_in_valid stall with no other effect.
- COMP+DRAIN length = R*(N/2+BF_LAT+1) cycles.
- UNLOAD+DONE = N+1 cycles. o_busy falls the cycle after o_done.
- A read and a write-back never coincide to the same address within a stage. This is guaranteed by DRAIN.
- o_wr_en is never active during LOAD or UNLOAD.

## Test plan
- Reset mid-COMP (s=2): all outputs 0 next cycle. A subsequent i_start gives o_in_ready=1 one cycle later, and no stray o_wr_en appears.
- Load 32 samples with valid de-asserted every third cycle: exactly 32 o_ld_we pulses. Sample 17 goes to bank 0, addr 8; sample 1 goes to bank 1, addr 0.
- Stage 0 issue:
  - b=0 -> a0=0, a1=8, swap=0, tw=0.
  - b=1 -> a0=8, a1=0, swap=1.
  - b=5 -> tw=5.
- Stage 1 and stage 4 issue:
  - Stage 1 b=9 -> p=17, q=25, tw=2, a0=8, a1=12, swap=0.
  - Stage 4 b=0 -> a0=0, a1=0, swap=0, tw=0.
- Write-back of each read appears exactly 4 cycles later (BF_LAT=3). Each stage is followed by 4 idle read cycles. The total from the first COMP cycle to UNLOAD entry is 100 cycles.
- UNLOAD: o_out_idx runs 0..31 contiguously. k=1 reads x=16 -> addr 8, bank 1. o_done pulses with k=31, then o_busy=0. An i_start asserted during UNLOAD is ignored.

Source files
------------

// File: rtl/fft_ctrl_if.sv
// Sample/bank/butterfly control bundle between the FFT sequencer and its datapath.
// master = sequencer side, slave = datapath / sample-source side.
interface fft_ctrl_if #(
   parameter int R = 5
);
   logic          i_start;
   logic          o_busy;
   logic          o_done;
   logic          i_in_valid;
   logic          o_in_ready;
   logic          o_ld_we;
   logic          o_ld_bank;
   logic [R-2:0]  o_ld_addr;
   logic          o_rd_en;
   logic [R-2:0]  o_rd_a0;
   logic [R-2:0]  o_rd_a1;
   logic          o_rd_swap;
   logic [R-2:0]  o_tw_idx;
   logic          o_wr_en;
   logic [R-2:0]  o_wr_a0;
   logic [R-2:0]  o_wr_a1;
   logic          o_wr_swap;
   logic          o_out_valid;
   logic [R-1:0]  o_out_idx;
   logic          o_out_bank;

   modport master (
      input  i_start, i_in_valid,
      output o_busy, o_done, o_in_ready, o_ld_we, o_ld_bank, o_ld_addr,
             o_rd_en, o_rd_a0, o_rd_a1, o_rd_swap, o_tw_idx,
             o_wr_en, o_wr_a0, o_wr_a1, o_wr_swap,
             o_out_valid, o_out_idx, o_out_bank
   );

   modport slave (
      output i_start, i_in_valid,
      input  o_busy, o_done, o_in_ready, o_ld_we, o_ld_bank, o_ld_addr,
             o_rd_en, o_rd_a0, o_rd_a1, o_rd_swap, o_tw_idx,
             o_wr_en, o_wr_a0, o_wr_a1, o_wr_swap,
             o_out_valid, o_out_idx, o_out_bank
   );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIF FFT sequencer: loads N samples into two parity-mapped
// banks, runs R butterfly stages (one read per cycle, write-back BF_LAT+1
// cycles later, a drain gap after every stage), then unloads in natural
// frequency order.
module fft_ctrl #(
   parameter int R      = 5,
   parameter int N      = 32,
   parameter int BF_LAT = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   fft_ctrl_if.master bus
);

   localparam int AW  = R - 1;
   localparam int SW  = (R > 1) ? $clog2(R) : 1;
   localparam int DEP = BF_LAT + 1;
   localparam int DW  = (DEP > 1) ? $clog2(DEP) : 1;

   localparam logic [R-1:0]  ONE_R   = {{(R-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] ONE_AW  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] ONE_SW  = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] ONE_DW  = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [R-1:0]  LAST_K  = {R{1'b1}};
   localparam logic [AW-1:0] LAST_B  = {AW{1'b1}};
   localparam logic [SW-1:0] LAST_S  = SW'(R - 1);
   localparam logic [DW-1:0] LAST_DR = DW'(BF_LAT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_COMP   = 3'd2,
      S_DRAIN  = 3'd3,
      S_UNLOAD = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Read-side descriptor of one issued butterfly.
   typedef struct packed {
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          swap;
      logic [AW-1:0] tw;
   } bf_t;

   // Write-back descriptor carried through the latency line.
   typedef struct packed {
      logic          v;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic          swap;
   } wb_t;

   localparam bf_t BF_ZERO = {{AW{1'b0}}, {AW{1'b0}}, 1'b0, {AW{1'b0}}};
   localparam wb_t WB_ZERO = {1'b0, {AW{1'b0}}, {AW{1'b0}}, 1'b0};

   // Even parity of a sample index selects its bank.
   function automatic logic par_f(input logic [R-1:0] x);
      return ^x;
   endfunction

   // Bank address of bitrev(x) for the low R-1 bits of x: the top index bit
   // of x lands on bit 0 of bitrev(x), which the >>1 discards.
   function automatic logic [AW-1:0] rev_addr_f(input logic [AW-1:0] x);
      logic [AW-1:0] r;
      for (int i = 0; i < AW; i++) begin
         r[i] = x[AW-1-i];
      end
      return r;
   endfunction

   // Operand addresses, swap and twiddle index for butterfly b of stage s.
   function automatic bf_t bf_calc(input logic [SW-1:0] s, input logic [AW-1:0] b);
      int  m;
      int  bi;
      int  lo;
      int  pi;
      int  qi;
      bf_t r;
      m  = R - 1 - int'(s);
      bi = int'(b);
      lo = bi & ((32'sd1 << m) - 32'sd1);
      pi = ((bi >> m) << (m + 1)) | lo;
      qi = pi | (32'sd1 << m);
      r.swap = ^pi;
      if (r.swap) begin
         r.a0 = AW'(qi >> 1);
         r.a1 = AW'(pi >> 1);
      end else begin
         r.a0 = AW'(pi >> 1);
         r.a1 = AW'(qi >> 1);
      end
      r.tw = AW'(lo << int'(s));
      return r;
   endfunction

   state_t        st_r;
   logic [R-1:0]  ld_k_r;
   logic [R-1:0]  k_r;
   logic [SW-1:0] s_r;
   logic [AW-1:0] b_r;
   logic [DW-1:0] dr_r;
   logic          busy_r;
   logic          done_r;
   logic          in_ready_r;
   logic          rd_en_r;
   bf_t           rd_bf_r;
   logic          out_valid_r;
   logic [R-1:0]  out_idx_r;
   logic          out_bank_r;
   wb_t           dl_r [DEP];

   bf_t           bf_nx_s;
   bf_t           bf_stage_s;
   bf_t           bf_first_s;
   logic [AW-1:0] k_lo_nx_s;
   logic          ld_we_s;

   assign bf_nx_s    = bf_calc(s_r, b_r + ONE_AW);
   assign bf_stage_s = bf_calc(s_r + ONE_SW, {AW{1'b0}});
   assign bf_first_s = bf_calc({SW{1'b0}}, {AW{1'b0}});
   assign k_lo_nx_s  = k_r[AW-1:0] + ONE_AW;
   assign ld_we_s    = in_ready_r & bus.i_in_valid;

   // Sequencer FSM: state, counters and all registered read/output strobes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st_r        <= S_IDLE;
         ld_k_r      <= {R{1'b0}};
         k_r         <= {R{1'b0}};
         s_r         <= {SW{1'b0}};
         b_r         <= {AW{1'b0}};
         dr_r        <= {DW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         rd_en_r     <= 1'b0;
         rd_bf_r     <= BF_ZERO;
         out_valid_r <= 1'b0;
         out_idx_r   <= {R{1'b0}};
         out_bank_r  <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         done_r      <= 1'b0;
         case (st_r)
            S_IDLE: begin
               if (bus.i_start) begin
                  st_r       <= S_LOAD;
                  busy_r     <= 1'b1;
                  in_ready_r <= 1'b1;
                  ld_k_r     <= {R{1'b0}};
               end else begin
                  busy_r     <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.i_in_valid) begin
                  ld_k_r <= ld_k_r + ONE_R;
                  if (ld_k_r == LAST_K) begin
                     st_r       <= S_COMP;
                     in_ready_r <= 1'b0;
                     s_r        <= {SW{1'b0}};
                     b_r        <= {AW{1'b0}};
                     rd_en_r    <= 1'b1;
                     rd_bf_r    <= bf_first_s;
                  end else begin
                     in_ready_r <= 1'b1;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            S_COMP: begin
               if (b_r == LAST_B) begin
                  st_r    <= S_DRAIN;
                  dr_r    <= {DW{1'b0}};
                  rd_en_r <= 1'b0;
                  rd_bf_r <= BF_ZERO;
               end else begin
                  b_r     <= b_r + ONE_AW;
                  rd_bf_r <= bf_nx_s;
               end
            end
            S_DRAIN: begin
               if (dr_r == LAST_DR) begin
                  rd_en_r <= 1'b1;
                  if (s_r == LAST_S) begin
                     st_r    <= S_UNLOAD;
                     k_r     <= {R{1'b0}};
                     rd_bf_r <= BF_ZERO;
                  end else begin
                     st_r    <= S_COMP;
                     s_r     <= s_r + ONE_SW;
                     b_r     <= {AW{1'b0}};
                     rd_bf_r <= bf_stage_s;
                  end
               end else begin
                  dr_r <= dr_r + ONE_DW;
               end
            end
            S_UNLOAD: begin
               out_valid_r <= 1'b1;
               out_idx_r   <= k_r;
               out_bank_r  <= par_f(k_r);
               if (k_r == LAST_K) begin
                  st_r    <= S_DONE;
                  done_r  <= 1'b1;
                  rd_en_r <= 1'b0;
                  rd_bf_r <= BF_ZERO;
               end else begin
                  k_r     <= k_r + ONE_R;
                  rd_bf_r <= {rev_addr_f(k_lo_nx_s), rev_addr_f(k_lo_nx_s), 1'b0, {AW{1'b0}}};
               end
            end
            S_DONE: begin
               st_r   <= S_IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               st_r       <= S_IDLE;
               busy_r     <= 1'b0;
               in_ready_r <= 1'b0;
               rd_en_r    <= 1'b0;
            end
         endcase
      end
   end

   // Write-back latency line: each butterfly read re-emerges DEP cycles later.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEP; i++) begin
            dl_r[i] <= WB_ZERO;
         end
      end else begin
         dl_r[0] <= {rd_en_r && (st_r == S_COMP), rd_bf_r.a0, rd_bf_r.a1, rd_bf_r.swap};
         for (int i = 1; i < DEP; i++) begin
            dl_r[i] <= dl_r[i-1];
         end
      end
   end

   assign bus.o_busy      = busy_r;
   assign bus.o_done      = done_r;
   assign bus.o_in_ready  = in_ready_r;
   assign bus.o_ld_we     = ld_we_s;
   assign bus.o_ld_bank   = ld_we_s & par_f(ld_k_r);
   assign bus.o_ld_addr   = ld_we_s ? ld_k_r[R-1:1] : {AW{1'b0}};
   assign bus.o_rd_en     = rd_en_r;
   assign bus.o_rd_a0     = rd_bf_r.a0;
   assign bus.o_rd_a1     = rd_bf_r.a1;
   assign bus.o_rd_swap   = rd_bf_r.swap;
   assign bus.o_tw_idx    = rd_bf_r.tw;
   assign bus.o_wr_en     = dl_r[DEP-1].v;
   assign bus.o_wr_a0     = dl_r[DEP-1].a0;
   assign bus.o_wr_a1     = dl_r[DEP-1].a1;
   assign bus.o_wr_swap   = dl_r[DEP-1].swap;
   assign bus.o_out_valid = out_valid_r;
   assign bus.o_out_idx   = out_idx_r;
   assign bus.o_out_bank  = out_bank_r;

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: a cycle-indexed model of the transform schedule,
// checked against every DUT output on every falling edge.
module tb_fft_ctrl;
   localparam int R        = 5;
   localparam int N        = 32;
   localparam int BFL      = 3;
   localparam int HALF     = N / 2;
   localparam int SLOT     = HALF + BFL + 1;
   localparam int COMP_LEN = R * SLOT;

   logic clk = 1'b0;
   logic rst;
   int   cyc     = 0;
   int   n_chk   = 0;
   int   n_err   = 0;
   int   m_phase = 0;
   int   m_k     = 0;
   int   m_t0    = 0;
   int   m_ldc   = 0;

   fft_ctrl_if #(.R(R)) bus();

   fft_ctrl #(.R(R), .N(N), .BF_LAT(BFL)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int brev(input int x);
      int r = 0;
      for (int i = 0; i < R; i++) begin
         if (((x >> i) & 1) != 0) r = r | (1 << (R - 1 - i));
      end
      return r;
   endfunction

   function automatic int par(input int x);
      return $countones(x) & 1;
   endfunction

   // Spec formulas: p/q operand indices, bank mapping and twiddle.
   task automatic bf_exp(input int s, input int b, output int a0, output int a1,
                         output int sw, output int tw);
      int m, p, q;
      m  = R - 1 - s;
      p  = ((b >> m) << (m + 1)) | (b % (1 << m));
      q  = p + (1 << m);
      sw = par(p);
      a0 = sw ? q / 2 : p / 2;
      a1 = sw ? p / 2 : q / 2;
      tw = (b % (1 << m)) << s;
   endtask

   task automatic check_idle();
      chk("idle_busy",     int'(bus.o_busy),      0);
      chk("idle_ready",    int'(bus.o_in_ready),  0);
      chk("idle_ld_we",    int'(bus.o_ld_we),     0);
      chk("idle_rd_en",    int'(bus.o_rd_en),     0);
      chk("idle_wr_en",    int'(bus.o_wr_en),     0);
      chk("idle_out_vld",  int'(bus.o_out_valid), 0);
      chk("idle_done",     int'(bus.o_done),      0);
   endtask

   // One cycle: compare at the falling edge, advance the model, then step.
   task automatic tick();
      int r, u, rw, e_rd, e_wr, e_ov, a0, a1, sw, tw;
      @(negedge clk);
      case (m_phase)
         0: begin
            check_idle();
            if (bus.i_start && !rst) begin
               m_phase = 1;
               m_k     = 0;
               m_ldc   = 0;
            end
         end
         1: begin
            chk("ld_busy",   int'(bus.o_busy),      1);
            chk("ld_ready",  int'(bus.o_in_ready),  1);
            chk("ld_we",     int'(bus.o_ld_we),     int'(bus.i_in_valid));
            chk("ld_rd_en",  int'(bus.o_rd_en),     0);
            chk("ld_wr_en",  int'(bus.o_wr_en),     0);
            chk("ld_out_vld", int'(bus.o_out_valid), 0);
            if (bus.o_ld_we) m_ldc++;
            if (bus.i_in_valid) begin
               chk("ld_bank", int'(bus.o_ld_bank), par(m_k));
               chk("ld_addr", int'(bus.o_ld_addr), m_k / 2);
               if (m_k == 17) begin
                  chk("ld17_bank", int'(bus.o_ld_bank), 0);
                  chk("ld17_addr", int'(bus.o_ld_addr), 8);
               end
               if (m_k == 1) begin
                  chk("ld1_bank", int'(bus.o_ld_bank), 1);
                  chk("ld1_addr", int'(bus.o_ld_addr), 0);
               end
               m_k++;
               if (m_k == N) begin
                  chk("ld_pulses", m_ldc, N);
                  m_phase = 2;
                  m_t0    = cyc + 1;
               end
            end
         end
         default: begin
            r = cyc - m_t0;
            e_rd = 0; e_wr = 0; e_ov = 0;
            if (r < COMP_LEN) begin
               if ((r % SLOT) < HALF) begin
                  e_rd = 1;
                  bf_exp(r / SLOT, r % SLOT, a0, a1, sw, tw);
                  chk("rd_a0",   int'(bus.o_rd_a0),   a0);
                  chk("rd_a1",   int'(bus.o_rd_a1),   a1);
                  chk("rd_swap", int'(bus.o_rd_swap), sw);
                  chk("tw_idx",  int'(bus.o_tw_idx),  tw);
               end
            end else if (r < COMP_LEN + N) begin
               e_rd = 1;
               u = r - COMP_LEN;
               chk("ul_a0", int'(bus.o_rd_a0), brev(u) / 2);
               chk("ul_a1", int'(bus.o_rd_a1), brev(u) / 2);
            end
            chk("rd_en", int'(bus.o_rd_en), e_rd);
            rw = r - (BFL + 1);
            if (rw >= 0 && rw < COMP_LEN && (rw % SLOT) < HALF) begin
               e_wr = 1;
               bf_exp(rw / SLOT, rw % SLOT, a0, a1, sw, tw);
               chk("wr_a0",   int'(bus.o_wr_a0),   a0);
               chk("wr_a1",   int'(bus.o_wr_a1),   a1);
               chk("wr_swap", int'(bus.o_wr_swap), sw);
            end
            chk("wr_en", int'(bus.o_wr_en), e_wr);
            u = r - COMP_LEN - 1;
            if (u >= 0 && u < N) begin
               e_ov = 1;
               chk("out_idx",  int'(bus.o_out_idx),  u);
               chk("out_bank", int'(bus.o_out_bank), par(brev(u)));
            end
            chk("out_valid", int'(bus.o_out_valid), e_ov);
            chk("done",      int'(bus.o_done),      int'(r == COMP_LEN + N));
            chk("run_busy",  int'(bus.o_busy),      1);
            chk("run_ready", int'(bus.o_in_ready),  0);
            chk("run_ld_we", int'(bus.o_ld_we),     0);
            // Hand-computed pins.
            if (r == 0) begin
               chk("s0b0_a1", int'(bus.o_rd_a1), 8);
               chk("s0b0_sw", int'(bus.o_rd_swap), 0);
            end
            if (r == 1) begin
               chk("s0b1_a0", int'(bus.o_rd_a0), 8);
               chk("s0b1_a1", int'(bus.o_rd_a1), 0);
               chk("s0b1_sw", int'(bus.o_rd_swap), 1);
            end
            if (r == 5)  chk("s0b5_tw", int'(bus.o_tw_idx), 5);
            if (r == 4)  chk("wb_b0_a1", int'(bus.o_wr_a1), 8);
            if (r == SLOT + 9) begin
               chk("s1b9_a0", int'(bus.o_rd_a0), 8);
               chk("s1b9_a1", int'(bus.o_rd_a1), 12);
               chk("s1b9_sw", int'(bus.o_rd_swap), 0);
               chk("s1b9_tw", int'(bus.o_tw_idx), 2);
            end
            if (r == 4 * SLOT) begin
               chk("s4b0_a0", int'(bus.o_rd_a0), 0);
               chk("s4b0_a1", int'(bus.o_rd_a1), 0);
               chk("s4b0_tw", int'(bus.o_tw_idx), 0);
            end
            if (r == 99)  chk("drain_last_rd", int'(bus.o_rd_en), 0);
            if (r == 100) chk("ul_entry_rd",   int'(bus.o_rd_en), 1);
            if (r == 101) chk("ul_k1_addr",    int'(bus.o_rd_a0), 8);
            if (r == 102) begin
               chk("ul_k1_idx",  int'(bus.o_out_idx), 1);
               chk("ul_k1_bank", int'(bus.o_out_bank), 1);
            end
            if (r == 132) chk("done_idx", int'(bus.o_out_idx), 31);
            if (r == COMP_LEN + N) m_phase = 0;
         end
      endcase
      if (rst) m_phase = 0;
      @(posedge clk);
      #1;
   endtask

   // One transaction: start, load (optionally gapped), then run until idle,
   // optionally resetting or re-asserting start at a given run cycle.
   task automatic run(input int gap, input int rst_at, input int start_at);
      int j = 0;
      int guard = 0;
      bus.i_start    = 1'b1;
      bus.i_in_valid = 1'b0;
      tick();
      bus.i_start = 1'b0;
      while (m_phase == 1 && guard < 200) begin
         bus.i_in_valid = (gap != 0) ? ((j % 3) != 2) : 1'b1;
         j++;
         guard++;
         tick();
      end
      chk("load_bound", int'(guard >= 200), 0);
      guard = 0;
      while (m_phase == 2 && guard < 300) begin
         bus.i_in_valid = guard[0];
         rst            = ((cyc - m_t0) == rst_at);
         bus.i_start    = ((cyc - m_t0) == start_at);
         guard++;
         tick();
      end
      chk("run_bound", int'(guard >= 300), 0);
      rst            = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_in_valid = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      bus.i_start    = 1'b0;
      bus.i_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.i_in_valid = (i % 2) == 1;
         tick();
      end
      run(1, 2 * SLOT + 5, -1);
      run(1, -1, 110);
      tick();
      run(0, -1, -1);
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
